spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 26, frame length in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, CLK cycles without an sclk edge before a partial frame is aborted.
REQ-003 SHALL have ports, clock and reset first:
- CLK  in  1  system clock; one clock domain.
- RST  in  1  reset; synchronous, active-high.
- sclk  in  1  SPI clock from master, asynchronous, idle low.
- mosi  in  1  master-out data, asynchronous.
- miso  out  1  slave-out data.
- tx_enq__ENA  in  1  load next transmit word.
- tx_enq_data  in  WIDTH  transmit word.
- tx_enq__RDY  out  1  transmit buffer empty.
- rx_enq__ENA  out  1  received word valid.
- rx_enq_data  out  WIDTH  received word.
- rx_enq__RDY  in  1  consumer accepts received word.
- busy  out  1  frame in progress.
- overrun_cnt  out  8  dropped receive frames, saturating.
- underrun_cnt  out  8  frames sent without a loaded tx word, saturating.

Function
REQ-004 SHALL pass sclk and mosi through a 2-flop synchronizer, then detect rise and fall edges; edge-to-action latency is 3 CLK cycles.
REQ-005 SHALL require sclk high and low phases of at least 4 CLK periods each; shorter phases are unsupported.
REQ-006 SHALL implement states IDLE and SHIFT.
REQ-007 In IDLE, the first sclk rise SHALL enter SHIFT with bit count 1. tx_shift SHALL load from tx_buf if tx_buf is full, otherwise all zeros with underrun_cnt incremented. tx_buf SHALL then be marked empty.
REQ-008 miso SHALL equal tx_buf MSB in IDLE when tx_buf is full, 0 when tx_buf is empty, and tx_shift MSB in SHIFT.
REQ-009 Data SHALL be MSB-first: mosi sampled into rx_shift LSB on each sclk rise; tx_shift shifted left, zero-fill, on each sclk fall.
REQ-010 When the count reaches WIDTH on a rise, the frame SHALL complete. State returns to IDLE and count clears.
REQ-011 On completion with the rx holding register empty, the holding register SHALL take rx_shift and rx_enq__ENA SHALL assert on the next cycle.
REQ-012 On completion with the rx holding register full, the new word SHALL be dropped, held data kept, and overrun_cnt incremented.
REQ-013 rx_enq__ENA SHALL remain high, with rx_enq_data stable, until a cycle with rx_enq__RDY high; it SHALL deassert the following cycle.
REQ-014 If rx acceptance and frame completion occur in the same cycle, the new word SHALL load and ENA SHALL stay high with no overrun.
REQ-015 tx_enq__RDY SHALL equal "tx_buf empty". tx_enq__ENA while tx_enq__RDY is low SHALL be ignored.
REQ-016 If tx load and frame-start consume occur in the same cycle, the old word SHALL be consumed and the new word SHALL fill tx_buf.
REQ-017 In SHIFT, TIMEOUT consecutive cycles without an sclk edge SHALL abort the frame: return to IDLE, count cleared, rx_shift discarded, no rx_enq__ENA.
REQ-018 busy SHALL be high exactly while in SHIFT.
REQ-019 Both counters SHALL saturate at 255.

Reset
REQ-020 While RST is high at a CLK edge, the block SHALL set state IDLE and clear count, timeout counter, tx_buf/rx holding valid flags, shift registers, synchronizers, both counters, miso, rx_enq__ENA, rx_enq_data, and busy; tx_enq__RDY SHALL be 1.
REQ-021 A reset mid-frame SHALL abandon the frame; the next sclk rise after release starts a new frame.

Structure
REQ-022 The state enum and the default WIDTH/TIMEOUT constants SHALL live in package spi_pkg, shared with the master.
REQ-023 The synchronizer and edge detector SHALL be sub-module spi_edge_sync, instantiated twice: sclk with edges, mosi level only.

Verification
REQ-024 The bench SHALL cover these directed scenarios (WIDTH=26):
- Load tx 26'h2A5A5A5, master sends 26'h1234567 -> miso stream equals 26'h2A5A5A5; rx_enq_data 26'h1234567 with one ENA pulse.
- No tx load, one frame -> miso all zeros, underrun_cnt=1.
- rx_enq__RDY held low across two frames -> first word retained, overrun_cnt=1; with RDY raised, exactly one handshake.
- Master stops after 10 bits for 300 cycles, then a full frame 26'h3FFFFFF -> abort, no ENA; then rx 26'h3FFFFFF.
- RST pulse after bit 13 -> all outputs at reset values; next full frame is received correctly.
- tx_enq__ENA on the same cycle as frame start -> old word transmitted; new word sent in the next frame.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding, default frame constants and helpers
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

  localparam int SPI_WIDTH   = 26;
  localparam int SPI_TIMEOUT = 255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// rtl/spi_edge_sync.sv - two-flop synchronizer with rise/fall detection on the synchronized level
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - mode-0 SPI slave with one-word tx buffer, rx holding register and frame timeout
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH   = SPI_WIDTH,
  parameter int TIMEOUT = SPI_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic             tx_enq__ENA,
  input  logic [WIDTH-1:0] tx_enq_data,
  output logic             tx_enq__RDY,
  output logic             rx_enq__ENA,
  output logic [WIDTH-1:0] rx_enq_data,
  input  logic             rx_enq__RDY,
  output logic             busy,
  output logic [7:0]       overrun_cnt,
  output logic [7:0]       underrun_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  spi_state_t       state, state_d;
  logic [CW-1:0]    count, count_d;
  logic [TW-1:0]    tmo, tmo_d;
  logic [WIDTH-1:0] tx_buf, tx_buf_d, tx_shift, tx_shift_d;
  logic [WIDTH-1:0] rx_shift, rx_shift_d, rx_data_d;
  logic             tx_full, tx_full_d, rx_valid_d, miso_d, consume;
  logic [7:0]       ovr_d, und_d;
  logic             sclk_s, sclk_rise, sclk_fall, mosi_s;
  logic             mosi_rise_unused, mosi_fall_unused;

  spi_edge_sync u_sclk_sync (
    .clk(CLK), .rst(RST), .d(sclk), .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_edge_sync u_mosi_sync (
    .clk(CLK), .rst(RST), .d(mosi), .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      count        <= '0;
      tmo          <= '0;
      tx_buf       <= '0;
      tx_full      <= 1'b0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      rx_enq_data  <= '0;
      rx_enq__ENA  <= 1'b0;
      overrun_cnt  <= '0;
      underrun_cnt <= '0;
      miso         <= 1'b0;
    end else begin
      state        <= state_d;
      count        <= count_d;
      tmo          <= tmo_d;
      tx_buf       <= tx_buf_d;
      tx_full      <= tx_full_d;
      tx_shift     <= tx_shift_d;
      rx_shift     <= rx_shift_d;
      rx_enq_data  <= rx_data_d;
      rx_enq__ENA  <= rx_valid_d;
      overrun_cnt  <= ovr_d;
      underrun_cnt <= und_d;
      miso         <= miso_d;
    end
  end

  always_comb begin
    state_d    = state;
    count_d    = count;
    tmo_d      = tmo;
    tx_buf_d   = tx_buf;
    tx_full_d  = tx_full;
    tx_shift_d = tx_shift;
    rx_shift_d = rx_shift;
    rx_data_d  = rx_enq_data;
    rx_valid_d = rx_enq__ENA;
    ovr_d      = overrun_cnt;
    und_d      = underrun_cnt;
    consume    = 1'b0;

    if (rx_enq__ENA && rx_enq__RDY) rx_valid_d = 1'b0;

    case (state)
      IDLE: begin
        if (sclk_rise) begin
          state_d    = SHIFT;
          count_d    = CW'(1);
          tmo_d      = '0;
          rx_shift_d = WIDTH'(mosi_s);
          consume    = 1'b1;
          if (tx_full) begin
            tx_shift_d = tx_buf;
          end else begin
            tx_shift_d = '0;
            und_d      = sat_inc(underrun_cnt);
          end
          tx_full_d = 1'b0;
        end
      end
      SHIFT: begin
        tmo_d = '0;
        if (sclk_rise) begin
          rx_shift_d = (rx_shift << 1) | WIDTH'(mosi_s);
          count_d    = count + 1'b1;
          if (count_d == CW'(WIDTH)) begin
            state_d = IDLE;
            count_d = '0;
            // A same-cycle handshake has already freed the holding register.
            if (!rx_valid_d) begin
              rx_data_d  = rx_shift_d;
              rx_valid_d = 1'b1;
            end else begin
              ovr_d = sat_inc(overrun_cnt);
            end
          end
        end else if (sclk_fall) begin
          tx_shift_d = tx_shift << 1;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          state_d    = IDLE;
          count_d    = '0;
          rx_shift_d = '0;
        end else begin
          tmo_d = tmo + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The frame-start consume frees the buffer, so a load in that cycle is taken.
    if (tx_enq__ENA && (!tx_full || consume)) begin
      tx_buf_d  = tx_enq_data;
      tx_full_d = 1'b1;
    end

    miso_d = (state_d == SHIFT) ? tx_shift_d[WIDTH-1] : (tx_full_d & tx_buf_d[WIDTH-1]);
  end

  assign tx_enq__RDY = ~tx_full;
  assign busy        = (state == SHIFT);

endmodule
